mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access.
// Data wins ties; fetch is forced ahead after STARVE_MAX data completions.
module mem_arbiter #(
   parameter int WORD_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic [WORD_W-1:0] iload,
   output logic              iwait,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic [WORD_W-1:0] dload,
   output logic              dwait,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              err
);

   localparam int         CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   typedef enum logic [1:0] {IDLE, IGNT, DGNT} arbState_e;

   arbState_e        r_state;
   logic [CNT_W-1:0] r_starve;
   logic             r_entry;

   logic w_ramDone;
   logic w_iActive;
   logic w_dActive;
   logic w_complete;
   logic w_starved;

   // A grant whose requester has withdrawn never completes, even if the RAM reports done.
   assign w_ramDone  = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
   assign w_iActive  = (r_state == IGNT) && iREN;
   assign w_dActive  = (r_state == DGNT) && (dREN || dWEN);
   assign w_complete = (w_iActive || w_dActive) && w_ramDone;
   assign w_starved  = iREN && (r_starve == CNT_W'(STARVE_MAX));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= IDLE;
         r_starve <= '0;
         r_entry  <= 1'b0;
      end else begin
         r_entry <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!iREN)
                  r_starve <= '0;
               if (w_starved) begin
                  r_state <= IGNT;
                  r_entry <= 1'b1;
               end else if (dREN || dWEN) begin
                  r_state <= DGNT;
                  r_entry <= 1'b1;
               end else if (iREN) begin
                  r_state <= IGNT;
                  r_entry <= 1'b1;
               end
            end
            IGNT: begin
               if (!w_iActive)
                  r_state <= IDLE;
               else if (w_complete) begin
                  r_state  <= IDLE;
                  r_starve <= '0;
               end
            end
            DGNT: begin
               if (!w_dActive)
                  r_state <= IDLE;
               else if (w_complete) begin
                  r_state <= IDLE;
                  if (iREN && (r_starve != CNT_W'(STARVE_MAX)))
                     r_starve <= r_starve + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // RAM side is driven straight from the granted requester's live inputs.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iload    = '0;
      dload    = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      err      = 1'b0;
      case (r_state)
         IGNT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            if (w_complete) begin
               iwait = 1'b0;
               iload = ramload;
               err   = (ramstate == RAM_ERROR);
            end
         end
         DGNT: begin
            ramREN   = dREN && !dWEN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            err      = r_entry && dREN && dWEN;
            if (w_complete) begin
               dwait = 1'b0;
               dload = ramload;
               if (ramstate == RAM_ERROR)
                  err = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
